scircuit_stats_collector: RTL and testbench

// - Downstream consumer of the generated scircuit datapath's registered x/z result pair (32-bit signed).
// - Aligns the operand-issue valid with the datapath pipeline latency.
// - Accumulates per-frame statistics: signed sum of x, signed max/min of z.
// - Presents each frame result through a one-entry valid/ready output buffer.

---
 rtl/scircuit_pkg.sv | 17 +
 rtl/scircuit_valid_pipe.sv | 30 +++
 rtl/scircuit_stats_collector.sv | 139 +++++++++++++
 tb/tb_scircuit_stats_collector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scircuit_pkg.sv
// Shared definitions for the scircuit statistics collector: default width,
// FSM state type and the frame-sum width helper.
package scircuit_pkg;

    localparam int DEF_DATAWIDTH = 32;

    typedef enum logic {
        FIRST,
        ACCUM
    } state_e;

    // The sum grows by log2(frame length) bits so a full frame can never wrap.
    function automatic int sum_width(input int data_width, input int frame_len);
        return data_width + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/scircuit_valid_pipe.sv
// LAT-stage 1-bit shift register that delays operand-issue valid until the
// matching x/z result leaves the upstream datapath.
module scircuit_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid
);

    logic [LAT-1:0] pipe_q;
    logic [LAT-1:0] pipe_d;

    always_comb begin
        pipe_d = LAT'({pipe_q, in_valid});
    end

    // Cleared on reset so valids already in flight cannot fabricate samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid = pipe_q[LAT-1];

endmodule

// File: rtl/scircuit_stats_collector.sv
// Per-frame statistics over the scircuit x/z result stream: signed sum of x,
// signed max/min of z, delivered through a one-entry valid/ready buffer.
module scircuit_stats_collector
    import scircuit_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int FRAME_LEN = 8,
    parameter int LAT       = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    input  logic signed [DATAWIDTH-1:0]                    x,
    input  logic signed [DATAWIDTH-1:0]                    z,
    input  logic                                           out_ready,
    output logic                                           out_valid,
    output logic signed [DATAWIDTH+$clog2(FRAME_LEN)-1:0]  sum_x,
    output logic signed [DATAWIDTH-1:0]                    max_z,
    output logic signed [DATAWIDTH-1:0]                    min_z,
    output logic                                           overflow
);

    localparam int SUM_W = sum_width(DATAWIDTH, FRAME_LEN);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic smp_valid;

    scircuit_valid_pipe #(
        .LAT(LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .out_valid(smp_valid)
    );

    state_e                      state_q,     state_d;
    logic [CNT_W-1:0]            cnt_q,       cnt_d;
    logic signed [SUM_W-1:0]     acc_sum_q,   acc_sum_d;
    logic signed [DATAWIDTH-1:0] acc_max_q,   acc_max_d;
    logic signed [DATAWIDTH-1:0] acc_min_q,   acc_min_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [SUM_W-1:0]     sum_q,       sum_d;
    logic signed [DATAWIDTH-1:0] max_q,       max_d;
    logic signed [DATAWIDTH-1:0] min_q,       min_d;
    logic                        overflow_q,  overflow_d;

    logic signed [SUM_W-1:0]     x_ext;
    logic signed [SUM_W-1:0]     fold_sum;
    logic signed [DATAWIDTH-1:0] fold_max;
    logic signed [DATAWIDTH-1:0] fold_min;
    logic                        frame_done;
    logic                        buf_free;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_sum_d   = acc_sum_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        max_d       = max_q;
        min_d       = min_q;
        overflow_d  = overflow_q;

        // The fold values are what the accumulators become if this sample is taken.
        x_ext    = {{(SUM_W-DATAWIDTH){x[DATAWIDTH-1]}}, x};
        fold_sum = (state_q == FIRST) ? x_ext : acc_sum_q + x_ext;
        fold_max = (state_q == FIRST || z > acc_max_q) ? z : acc_max_q;
        fold_min = (state_q == FIRST || z < acc_min_q) ? z : acc_min_q;

        frame_done = smp_valid && (state_q == ACCUM) && (cnt_q == LAST_CNT);
        buf_free   = !out_valid_q || out_ready;

        if (smp_valid) begin
            acc_sum_d = fold_sum;
            acc_max_d = fold_max;
            acc_min_d = fold_min;
            if (state_q == FIRST) begin
                state_d = ACCUM;
                cnt_d   = CNT_W'(1);
            end else if (frame_done) begin
                state_d = FIRST;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A completed frame may replace a result leaving in this same cycle.
        if (frame_done && buf_free) begin
            out_valid_d = 1'b1;
            sum_d       = fold_sum;
            max_d       = fold_max;
            min_d       = fold_min;
        end else if (frame_done) begin
            overflow_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FIRST;
            cnt_q       <= '0;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_sum_q   <= acc_sum_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            min_q       <= min_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_x     = sum_q;
    assign max_z     = max_q;
    assign min_z     = min_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_scircuit_stats_collector.sv
// Directed bench for scircuit_stats_collector (FRAME_LEN=4, LAT=2) with a
// frame-level reference model compared against the DUT on every cycle.
module tb_scircuit_stats_collector;

    localparam int DW  = 32;
    localparam int FL  = 4;
    localparam int LAT = 2;
    localparam int SW  = DW + $clog2(FL);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] x = '0;
    logic signed [DW-1:0] z = '0;
    logic                 out_ready = 1'b1;
    logic                 out_valid;
    logic signed [SW-1:0] sum_x;
    logic signed [DW-1:0] max_z;
    logic signed [DW-1:0] min_z;
    logic                 overflow;

    scircuit_stats_collector #(
        .DATAWIDTH(DW),
        .FRAME_LEN(FL),
        .LAT      (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x        (x),
        .z        (z),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .sum_x    (sum_x),
        .max_z    (max_z),
        .min_z    (min_z),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Reference model: operands issued now appear LAT clocks later; every FL
    // arrivals form a frame whose stats go to a one-slot output buffer.
    int     mcyc = 0;
    int     arr_q[$];
    longint fx[$];
    longint fz[$];
    bit     ev = 1'b0;
    longint es = 0;
    longint emax = 0;
    longint emin = 0;
    bit     eovf = 1'b0;

    always @(posedge clk) begin
        bit     done;
        longint s, mx, mn;
        if (rst) begin
            arr_q.delete();
            fx.delete();
            fz.delete();
            ev = 1'b0;
            es = 0;
            emax = 0;
            emin = 0;
            eovf = 1'b0;
        end else begin
            done = 1'b0;
            s = 0; mx = 0; mn = 0;
            if (arr_q.size() > 0 && arr_q[0] == mcyc) begin
                void'(arr_q.pop_front());
                fx.push_back(longint'(x));
                fz.push_back(longint'(z));
            end
            if (in_valid) arr_q.push_back(mcyc + LAT);
            if (fx.size() == FL) begin
                mx = fz[0];
                mn = fz[0];
                for (int i = 0; i < FL; i++) begin
                    s += fx[i];
                    if (fz[i] > mx) mx = fz[i];
                    if (fz[i] < mn) mn = fz[i];
                end
                fx.delete();
                fz.delete();
                done = 1'b1;
            end
            if (done && (!ev || out_ready)) begin
                ev = 1'b1;
                es = s;
                emax = mx;
                emin = mn;
            end else if (done) begin
                eovf = 1'b1;
            end else if (ev && out_ready) begin
                ev = 1'b0;
            end
        end
        mcyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out_valid", 64'(out_valid), 64'(ev));
            check("cyc_sum_x",     64'(sum_x),     es);
            check("cyc_max_z",     64'(max_z),     emax);
            check("cyc_min_z",     64'(min_z),     emin);
            check("cyc_overflow",  64'(overflow),  64'(eovf));
        end
    end

    // Stimulus: tick() issues operands whose results are xv/zv; the bench
    // itself presents those results on x/z LAT cycles later.
    int sc = 0;
    int pend_due[$];
    int pend_x[$];
    int pend_z[$];

    task automatic tick(input bit iv, input int xv, input int zv);
        in_valid = iv;
        if (pend_due.size() > 0 && pend_due[0] == sc) begin
            void'(pend_due.pop_front());
            x = pend_x.pop_front();
            z = pend_z.pop_front();
        end else begin
            x = $urandom;
            z = $urandom;
        end
        if (iv) begin
            pend_due.push_back(sc + LAT);
            pend_x.push_back(xv);
            pend_z.push_back(zv);
        end
        @(posedge clk);
        #1;
        sc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pend_due.delete();
        pend_x.delete();
        pend_z.delete();
        idle(n);
        rst = 1'b0;
    endtask

    task automatic wait_out(input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            tick(1'b0, 0, 0);
            n++;
            @(negedge clk);
        end
        check(name, 64'(out_valid), 64'(1));
    endtask

    task automatic lit_result(input string tag, input longint s, input longint mx, input longint mn);
        check({tag, "_sum_x"}, 64'(sum_x), s);
        check({tag, "_max_z"}, 64'(max_z), mx);
        check({tag, "_min_z"}, 64'(min_z), mn);
    endtask

    initial begin
        int n;

        // Reset state
        do_reset(2);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));
        lit_result("rst", 0, 0, 0);

        // Contiguous frame: result one cycle after the last sample
        tick(1'b1, 1, 5);
        tick(1'b1, 2, -3);
        tick(1'b1, 3, 7);
        tick(1'b1, 4, 0);
        wait_out("contig_valid", n);
        check("contig_latency", 64'(n), 64'(2));
        lit_result("contig", 10, 7, -3);
        idle(2);

        // Same samples with bubbles of 1..3 cycles
        tick(1'b1, 1, 5);
        idle(1);
        tick(1'b1, 2, -3);
        idle(2);
        tick(1'b1, 3, 7);
        idle(3);
        tick(1'b1, 4, 0);
        wait_out("bubble_valid", n);
        check("bubble_latency", 64'(n), 64'(2));
        lit_result("bubble", 10, 7, -3);
        idle(2);

        // Extremes
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_out("ext_valid", n);
        lit_result("ext", -64'sd8589934592, 64'sd2147483647, 64'sd2147483647);
        idle(2);

        // Backpressure across two frames: second result dropped
        out_ready = 1'b0;
        tick(1'b1, 1, 1);
        tick(1'b1, 1, 2);
        tick(1'b1, 1, 3);
        tick(1'b1, 1, 4);
        wait_out("bp_first_valid", n);
        lit_result("bp_first", 4, 4, 1);
        for (int i = 0; i < 4; i++) tick(1'b1, 5, 9);
        idle(6);
        @(negedge clk);
        check("bp_held_valid", 64'(out_valid), 64'(1));
        check("bp_overflow",   64'(overflow),  64'(1));
        lit_result("bp_held", 4, 4, 1);
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'(0));
        check("bp_sticky",  64'(overflow),  64'(1));
        do_reset(2);

        // Transfer and frame completion in the same cycle
        out_ready = 1'b0;
        tick(1'b1, 2, 3);
        tick(1'b1, 2, 1);
        tick(1'b1, 2, 4);
        tick(1'b1, 2, 1);
        wait_out("sc_first_valid", n);
        lit_result("sc_first", 8, 4, 1);
        tick(1'b1, -5, -100);
        tick(1'b1, 10, 50);
        tick(1'b1, 0, -7);
        tick(1'b1, 7, 20);
        idle(1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        @(negedge clk);
        check("sc_valid",    64'(out_valid), 64'(1));
        check("sc_overflow", 64'(overflow),  64'(0));
        lit_result("sc_second", 12, 50, -100);
        out_ready = 1'b1;
        idle(2);

        // Mid-frame reset with a valid still in the delay line
        tick(1'b1, 100, 100);
        tick(1'b1, 100, 100);
        idle(2);
        tick(1'b1, 55, 55);
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(1'b1, -1, -9);
        wait_out("mr_valid", n);
        lit_result("mr", -4, -9, -9);
        idle(4);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
